// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   Holds the EX/MEM pipeline register, resolves branches (pcsrc) and runs loads/stores
//   over a req/ack data-memory port that may insert wait states, stalling the pipeline
//   while an access is outstanding. Keeps sticky error flags and monitoring counters.
// Ports:
//   clk, reset                     clock (rising edge), synchronous active-high reset
//   *_ex, flush_mem                instruction fields from EX; flush inserts a bubble
//   mem_req/we/addr/wdata/ack/rdata data-memory handshake
//   stall_mem                      hold IF/ID/EX and the EX/MEM register
//   pcsrc, pc_branch_mem           branch taken and its target
//   ULAout_mem, write_reg_mem      registered ALU result / destination (also to forwarding)
//   regwrite_mem, memtoreg_mem     control to MEM/WB
//   readdata_mem                   load data to MEM/WB
//   mem_error, align_error         sticky timeout / misalignment flags
//   load_count ... branch_taken_count  wrapping 32-bit monitoring counters
module mem_stage #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ULAout_ex,
   input  logic [31:0] write_data_ex,
   input  logic [4:0]  write_reg_ex,
   input  logic [31:0] pc_branch_ex,
   input  logic        zero_ex,
   input  logic        regwrite_ex,
   input  logic        memtoreg_ex,
   input  logic        memwrite_ex,
   input  logic        branch_ex,
   input  logic        flush_mem,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        stall_mem,
   output logic        pcsrc,
   output logic [31:0] pc_branch_mem,
   output logic [31:0] ULAout_mem,
   output logic [4:0]  write_reg_mem,
   output logic        regwrite_mem,
   output logic        memtoreg_mem,
   output logic [31:0] readdata_mem,
   output logic        mem_error,
   output logic        align_error,
   output logic [31:0] load_count,
   output logic [31:0] store_count,
   output logic [31:0] wait_cycles,
   output logic [31:0] branch_taken_count
);

   typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

   // EX/MEM register
   logic [31:0] ula_q, wdata_q, pcb_q;
   logic [4:0]  wreg_q;
   logic        zero_q, regwrite_q, memtoreg_q, memwrite_q, branch_q;

   state_e      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic        mem_error_q, align_error_q;
   logic [31:0] load_cnt_q, store_cnt_q, wait_cnt_q, br_cnt_q;

   logic mem_op, misaligned, done, abort;

   assign mem_op     = memtoreg_q | memwrite_q;
   assign misaligned = mem_op & (ula_q[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         ula_q      <= '0;
         wdata_q    <= '0;
         pcb_q      <= '0;
         wreg_q     <= '0;
         zero_q     <= 1'b0;
         regwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         memwrite_q <= 1'b0;
         branch_q   <= 1'b0;
      end else if (!stall_mem) begin
         ula_q      <= ULAout_ex;
         wdata_q    <= write_data_ex;
         pcb_q      <= pc_branch_ex;
         wreg_q     <= write_reg_ex;
         zero_q     <= zero_ex;
         // A flush only kills the control bits; data fields are don't-care in a bubble.
         regwrite_q <= regwrite_ex & ~flush_mem;
         memtoreg_q <= memtoreg_ex & ~flush_mem;
         memwrite_q <= memwrite_ex & ~flush_mem;
         branch_q   <= branch_ex   & ~flush_mem;
      end
   end

   // Access FSM. wait_q counts stall cycles of the current access; the access is abandoned
   // after TIMEOUT stall cycles so the instruction is still held during the ABORT cycle.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      mem_req   = 1'b0;
      stall_mem = 1'b0;
      done      = 1'b0;
      abort     = 1'b0;
      unique case (state_q)
         StIdle: begin
            mem_req = mem_op & ~misaligned;
            if (mem_req) begin
               if (mem_ack) begin
                  done = 1'b1;
               end else begin
                  stall_mem = 1'b1;
                  state_d   = StBusy;
                  wait_d    = 8'd1;
               end
            end
         end
         StBusy: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               done    = 1'b1;
               state_d = StIdle;
               wait_d  = '0;
            end else begin
               stall_mem = 1'b1;
               wait_d    = wait_q + 8'd1;
               if (wait_q == 8'(TIMEOUT - 1)) state_d = StAbort;
            end
         end
         StAbort: begin
            abort   = 1'b1;
            state_d = StIdle;
            wait_d  = '0;
         end
         default: begin
            state_d = StIdle;
            wait_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         wait_q        <= '0;
         mem_error_q   <= 1'b0;
         align_error_q <= 1'b0;
         load_cnt_q    <= '0;
         store_cnt_q   <= '0;
         wait_cnt_q    <= '0;
         br_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         mem_error_q   <= mem_error_q | abort;
         align_error_q <= align_error_q | misaligned;
         if (done && memtoreg_q) load_cnt_q <= load_cnt_q + 32'd1;
         if (done && memwrite_q) store_cnt_q <= store_cnt_q + 32'd1;
         if (stall_mem) wait_cnt_q <= wait_cnt_q + 32'd1;
         if (pcsrc && !stall_mem) br_cnt_q <= br_cnt_q + 32'd1;
      end
   end

   always_comb begin
      readdata_mem = '0;
      if (misaligned || (abort && memtoreg_q)) begin
         readdata_mem = ERR_DATA;
      end else if (mem_req && mem_ack && memtoreg_q) begin
         readdata_mem = mem_rdata;
      end
   end

   assign mem_we             = mem_req & memwrite_q;
   assign mem_addr           = {ula_q[31:2], 2'b00};
   assign mem_wdata          = wdata_q;
   assign pcsrc              = branch_q & zero_q;
   assign pc_branch_mem      = pcb_q;
   assign ULAout_mem         = ula_q;
   assign write_reg_mem      = wreg_q;
   assign regwrite_mem       = regwrite_q & ~misaligned & ~abort;
   assign memtoreg_mem       = memtoreg_q;
   assign mem_error          = mem_error_q;
   assign align_error        = align_error_q;
   assign load_count         = load_cnt_q;
   assign store_count        = store_cnt_q;
   assign wait_cycles        = wait_cnt_q;
   assign branch_taken_count = br_cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

   localparam logic [31:0] ErrData = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ULAout_ex, write_data_ex, pc_branch_ex;
   logic [4:0]  write_reg_ex;
   logic        zero_ex, regwrite_ex, memtoreg_ex, memwrite_ex, branch_ex, flush_mem;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall_mem, pcsrc;
   logic [31:0] pc_branch_mem, ULAout_mem, readdata_mem;
   logic [4:0]  write_reg_mem;
   logic        regwrite_mem, memtoreg_mem, mem_error, align_error;
   logic [31:0] load_count, store_count, wait_cycles, branch_taken_count;

   int checks = 0;
   int errors = 0;

   mem_stage #(.TIMEOUT(4), .ERR_DATA(ErrData)) dut (
      .clk(clk), .reset(reset),
      .ULAout_ex(ULAout_ex), .write_data_ex(write_data_ex), .write_reg_ex(write_reg_ex),
      .pc_branch_ex(pc_branch_ex), .zero_ex(zero_ex), .regwrite_ex(regwrite_ex),
      .memtoreg_ex(memtoreg_ex), .memwrite_ex(memwrite_ex), .branch_ex(branch_ex),
      .flush_mem(flush_mem), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall_mem(stall_mem), .pcsrc(pcsrc), .pc_branch_mem(pc_branch_mem),
      .ULAout_mem(ULAout_mem), .write_reg_mem(write_reg_mem),
      .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
      .readdata_mem(readdata_mem), .mem_error(mem_error), .align_error(align_error),
      .load_count(load_count), .store_count(store_count), .wait_cycles(wait_cycles),
      .branch_taken_count(branch_taken_count)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      ULAout_ex     = '0;
      write_data_ex = '0;
      write_reg_ex  = '0;
      pc_branch_ex  = '0;
      zero_ex       = 1'b0;
      regwrite_ex   = 1'b0;
      memtoreg_ex   = 1'b0;
      memwrite_ex   = 1'b0;
      branch_ex     = 1'b0;
      flush_mem     = 1'b0;
   endtask

   task automatic test_reset();
      clear_ex();
      memtoreg_ex = 1'b1;
      branch_ex   = 1'b1;
      zero_ex     = 1'b1;
      mem_ack     = 1'b1;
      mem_rdata   = 32'h1111_2222;
      reset       = 1'b1;
      tick();
      tick();
      #1;
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", mem_req); end
      checks++;
      if (stall_mem !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_mem); end
      checks++;
      if (pcsrc !== 1'b0) begin errors++; $display("FAIL reset_pcsrc got %b want 0", pcsrc); end
      checks++;
      if (readdata_mem !== 32'h0) begin
         errors++; $display("FAIL reset_readdata got %h want 0", readdata_mem);
      end
      checks++;
      if ({load_count, store_count, wait_cycles, branch_taken_count} !== 128'h0) begin
         errors++; $display("FAIL reset_counters got %h %h %h %h want 0", load_count,
                            store_count, wait_cycles, branch_taken_count);
      end
      checks++;
      if ({mem_error, align_error} !== 2'b00) begin
         errors++; $display("FAIL reset_flags got %b%b want 00", mem_error, align_error);
      end
      clear_ex();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      reset     = 1'b0;
      tick();
   endtask

   task automatic test_zero_wait_load();
      ULAout_ex    = 32'h100;
      memtoreg_ex  = 1'b1;
      regwrite_ex  = 1'b1;
      write_reg_ex = 5'd5;
      tick();
      clear_ex();
      mem_ack   = 1'b1;
      mem_rdata = 32'hCAFE_0001;
      #1;
      checks++;
      if ({mem_req, stall_mem, mem_we} !== 3'b100) begin
         errors++; $display("FAIL zw_handshake got req/stall/we %b%b%b want 100", mem_req,
                            stall_mem, mem_we);
      end
      checks++;
      if (mem_addr !== 32'h100) begin errors++; $display("FAIL zw_addr got %h want 100", mem_addr); end
      checks++;
      if (readdata_mem !== 32'hCAFE_0001) begin
         errors++; $display("FAIL zw_readdata got %h want cafe0001", readdata_mem);
      end
      checks++;
      if ({regwrite_mem, write_reg_mem} !== {1'b1, 5'd5}) begin
         errors++; $display("FAIL zw_wb got %b %0d want 1 5", regwrite_mem, write_reg_mem);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL zw_req_drop got %b want 0", mem_req); end
      checks++;
      if ({load_count, wait_cycles} !== {32'd1, 32'd0}) begin
         errors++; $display("FAIL zw_counts got load %0d wait %0d want 1 0", load_count,
                            wait_cycles);
      end
   endtask

   task automatic test_wait_store();
      ULAout_ex     = 32'h204;
      write_data_ex = 32'h1234_5678;
      memwrite_ex   = 1'b1;
      tick();
      // Next instruction waits in EX; it must not enter while the store stalls.
      clear_ex();
      ULAout_ex   = 32'h999;
      regwrite_ex = 1'b1;
      mem_ack     = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if ({stall_mem, mem_req, mem_we} !== 3'b111) begin
            errors++; $display("FAIL ws_stall[%0d] got stall/req/we %b%b%b want 111", i,
                               stall_mem, mem_req, mem_we);
         end
         checks++;
         if ({mem_addr, mem_wdata, ULAout_mem} !== {32'h204, 32'h1234_5678, 32'h204}) begin
            errors++; $display("FAIL ws_hold[%0d] got %h %h %h want 204 12345678 204", i,
                               mem_addr, mem_wdata, ULAout_mem);
         end
         tick();
      end
      mem_ack = 1'b1;
      #1;
      checks++;
      if ({stall_mem, mem_req, mem_we} !== 3'b011) begin
         errors++; $display("FAIL ws_ack got stall/req/we %b%b%b want 011", stall_mem,
                            mem_req, mem_we);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      checks++;
      if (ULAout_mem !== 32'h999) begin
         errors++; $display("FAIL ws_advance got %h want 999", ULAout_mem);
      end
      checks++;
      if ({store_count, wait_cycles, load_count} !== {32'd1, 32'd3, 32'd1}) begin
         errors++; $display("FAIL ws_counts got store %0d wait %0d load %0d want 1 3 1",
                            store_count, wait_cycles, load_count);
      end
      checks++;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL ws_req_drop got %b want 0", mem_req); end
      clear_ex();
      tick();
   endtask

   task automatic test_timeout();
      ULAout_ex   = 32'h300;
      memtoreg_ex = 1'b1;
      regwrite_ex = 1'b1;
      tick();
      clear_ex();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if ({stall_mem, mem_req} !== 2'b11) begin
            errors++; $display("FAIL to_stall[%0d] got stall/req %b%b want 11", i,
                               stall_mem, mem_req);
         end
         tick();
      end
      // ABORT cycle; a late ack here must be ignored.
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      #1;
      checks++;
      if ({mem_req, stall_mem, regwrite_mem} !== 3'b000) begin
         errors++; $display("FAIL to_abort got req/stall/regwrite %b%b%b want 000", mem_req,
                            stall_mem, regwrite_mem);
      end
      checks++;
      if (readdata_mem !== ErrData) begin
         errors++; $display("FAIL to_errdata got %h want %h", readdata_mem, ErrData);
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = '0;
      #1;
      checks++;
      if ({mem_error, load_count, wait_cycles} !== {1'b1, 32'd1, 32'd7}) begin
         errors++; $display("FAIL to_after got err %b load %0d wait %0d want 1 1 7",
                            mem_error, load_count, wait_cycles);
      end
      tick();
      tick();
      checks++;
      if (mem_error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b want 1", mem_error); end
   endtask

   task automatic test_misaligned();
      ULAout_ex   = 32'h102;
      memtoreg_ex = 1'b1;
      regwrite_ex = 1'b1;
      tick();
      clear_ex();
      mem_ack   = 1'b1;
      mem_rdata = 32'h4444_4444;
      #1;
      checks++;
      if ({mem_req, stall_mem, regwrite_mem} !== 3'b000) begin
         errors++; $display("FAIL mis_ctrl got req/stall/regwrite %b%b%b want 000", mem_req,
                            stall_mem, regwrite_mem);
      end
      checks++;
      if (readdata_mem !== ErrData) begin
         errors++; $display("FAIL mis_data got %h want %h", readdata_mem, ErrData);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      checks++;
      if ({align_error, load_count} !== {1'b1, 32'd1}) begin
         errors++; $display("FAIL mis_flag got align %b load %0d want 1 1", align_error,
                            load_count);
      end
   endtask

   task automatic test_branch();
      branch_ex    = 1'b1;
      zero_ex      = 1'b1;
      pc_branch_ex = 32'h40;
      tick();
      clear_ex();
      #1;
      checks++;
      if ({pcsrc, pc_branch_mem} !== {1'b1, 32'h40}) begin
         errors++; $display("FAIL br_taken got %b %h want 1 40", pcsrc, pc_branch_mem);
      end
      tick();
      checks++;
      if ({pcsrc, branch_taken_count} !== {1'b0, 32'd1}) begin
         errors++; $display("FAIL br_count got %b %0d want 0 1", pcsrc, branch_taken_count);
      end
      branch_ex    = 1'b1;
      zero_ex      = 1'b1;
      pc_branch_ex = 32'h80;
      flush_mem    = 1'b1;
      tick();
      clear_ex();
      #1;
      checks++;
      if ({pcsrc, pc_branch_mem} !== {1'b0, 32'h80}) begin
         errors++; $display("FAIL br_flush got %b %h want 0 80", pcsrc, pc_branch_mem);
      end
      tick();
      checks++;
      if (branch_taken_count !== 32'd1) begin
         errors++; $display("FAIL br_flush_count got %0d want 1", branch_taken_count);
      end
   endtask

   task automatic test_reset_busy();
      ULAout_ex   = 32'h400;
      memtoreg_ex = 1'b1;
      regwrite_ex = 1'b1;
      tick();
      clear_ex();
      mem_ack = 1'b0;
      tick();                // BUSY 1
      tick();                // BUSY 2
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_req, stall_mem} !== 2'b00) begin
         errors++; $display("FAIL rb_ctrl got req/stall %b%b want 00", mem_req, stall_mem);
      end
      checks++;
      if ({load_count, store_count, wait_cycles, branch_taken_count} !== 128'h0) begin
         errors++; $display("FAIL rb_counters got %0d %0d %0d %0d want 0", load_count,
                            store_count, wait_cycles, branch_taken_count);
      end
      ULAout_ex   = 32'h500;
      memtoreg_ex = 1'b1;
      regwrite_ex = 1'b1;
      tick();
      clear_ex();
      mem_ack   = 1'b1;
      mem_rdata = 32'h55AA_55AA;
      #1;
      checks++;
      if ({mem_req, stall_mem, readdata_mem} !== {2'b10, 32'h55AA_55AA}) begin
         errors++; $display("FAIL rb_load got req/stall %b%b data %h want 10 55aa55aa",
                            mem_req, stall_mem, readdata_mem);
      end
      tick();
      mem_ack = 1'b0;
      #1;
      checks++;
      if (load_count !== 32'd1) begin
         errors++; $display("FAIL rb_load_count got %0d want 1", load_count);
      end
   endtask

   initial begin
      reset     = 1'b1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      clear_ex();
      test_reset();
      test_zero_wait_load();
      test_wait_store();
      test_timeout();
      test_misaligned();
      test_branch();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage in the 5-stage MIPS pipeline.
- Holds the EX/MEM pipeline register and resolves branches (pcsrc).
- Runs loads and stores over a req/ack data-memory port that may insert wait states. Stalls the pipeline while an access is outstanding.
- Supplies ULAout_mem and write_reg_mem to the forwarding unit. Keeps performance and error counters for monitoring.

Parameters:
TIMEOUT, 16, max cycles in BUSY before an access is aborted (2..255)
ERR_DATA, 32'h0000_0000, readdata value returned on an aborted load

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ULAout_ex  in  32  ALU result from EX (address or result)
write_data_ex  in  32  store data from EX (forwarded rt)
write_reg_ex  in  5  destination register from EX
pc_branch_ex  in  32  branch target from EX
zero_ex  in  1  ALU zero from EX
regwrite_ex, memtoreg_ex, memwrite_ex, branch_ex  in  1 each  control from EX
flush_mem  in  1  insert a bubble instead of the EX instruction
mem_req  out  1  data-memory request
mem_we  out  1  write strobe, valid only with mem_req
mem_addr  out  32  word address {ULAout_mem[31:2],2'b00}
mem_wdata  out  32  store data
mem_ack  in  1  access complete; mem_rdata valid this cycle
mem_rdata  in  32  load data
stall_mem  out  1  hold IF/ID/EX and the EX/MEM register
pcsrc  out  1  branch taken
pc_branch_mem  out  32  registered branch target
ULAout_mem  out  32  registered ALU result, also forwarded to EX
write_reg_mem  out  5  registered destination register
regwrite_mem, memtoreg_mem  out  1 each  control to MEM/WB
readdata_mem  out  32  load data to MEM/WB
mem_error  out  1  sticky: timeout occurred
align_error  out  1  sticky: misaligned access occurred
load_count, store_count, wait_cycles, branch_taken_count  out  32 each  monitoring counters

Behaviour:
- Reset (synchronous):
  - All EX/MEM fields are cleared, giving a bubble with all control bits 0.
  - FSM goes to IDLE. All counters are 0 and both sticky flags are 0.
  - Resulting output values: mem_req=0, stall_mem=0, pcsrc=0, readdata_mem=0.
- Reset during a BUSY access aborts it. mem_req is 0 from the next cycle. No counter increments for the aborted access.
- EX/MEM register:
  - Loads all *_ex fields on every edge where stall_mem=0.
  - If flush_mem=1 at that edge, only the control bits are loaded as 0. Data fields load normally.
  - When stall_mem=1, the register holds its value. A flush_mem asserted while stalled is ignored; the hazard unit must hold it until the stall clears.
- Definitions:
  - mem_op = memtoreg_mem | memwrite_mem.
  - misaligned = mem_op & (ULAout_mem[1:0] != 0).
- Misaligned access:
  - No request is issued and there is no stall.
  - align_error is set.
  - regwrite_mem is forced to 0 toward WB and readdata_mem = ERR_DATA.
- FSM states: IDLE, BUSY, ABORT.
  - IDLE:
    - mem_req = mem_op & !misaligned.
    - If mem_req & mem_ack: zero-wait access. No stall, stay in IDLE.
    - If mem_req & !mem_ack: stall_mem=1, go to BUSY, wait counter starts at 1.
  - BUSY:
    - mem_req=1 and mem_addr, mem_we, mem_wdata are held stable.
    - On mem_ack: stall_mem=0, go to IDLE.
    - Otherwise stall_mem=1 and the wait counter increments. When it reaches TIMEOUT, go to ABORT with mem_req dropped.
  - ABORT (one cycle):
    - mem_req=0, stall_mem=0, mem_error set.
    - A load returns ERR_DATA with regwrite_mem forced to 0.
    - Go to IDLE.
- stall_mem is combinational:
  - (IDLE & mem_req & !mem_ack) | (BUSY & !mem_ack & !timeout_hit).
  - An instruction therefore leaves the register in the same cycle its ack arrives.
- readdata_mem is combinational: mem_rdata when mem_ack & memtoreg_mem, else 0 (ERR_DATA in the error cases).
- mem_ack while mem_req=0 is ignored.
- pcsrc = branch_mem & zero_mem, combinational from the registered fields. It is independent of the stall.
- mem_we = mem_req & memwrite_mem.
- Counters:
  - load_count / store_count increment once per completed, non-aborted access, in the cycle of the ack.
  - wait_cycles increments every cycle stall_mem=1.
  - branch_taken_count increments on each cycle where pcsrc=1 & stall_mem=0.
  - All counters wrap modulo 2^32.

Test Plan:
- Zero-wait load: ULAout_ex=0x100, memtoreg=1, regwrite=1; ack in the same cycle with rdata=0xCAFE0001 -> mem_req for 1 cycle, stall_mem never 1, readdata_mem=0xCAFE0001, load_count=1.
- 3-wait-state store to 0x204, data 0x12345678: ack on the 3rd BUSY cycle -> stall_mem high 3 cycles, mem_addr/mem_wdata/mem_we stable throughout, wait_cycles=3, store_count=1, EX/MEM register held.
- Timeout, TIMEOUT=4, ack never arrives -> stall for 4 cycles, mem_req drops, ABORT cycle with regwrite_mem=0 and readdata=ERR_DATA, mem_error=1 and stays 1, load_count=0.
- Misaligned load at 0x102 -> mem_req=0, stall_mem=0, align_error=1, regwrite_mem=0.
- Branch: branch_ex=1, zero_ex=1, pc_branch_ex=0x40 -> the next cycle pcsrc=1, pc_branch_mem=0x40, branch_taken_count=1. Repeated with flush_mem=1 -> pcsrc=0.
- Reset asserted during the 2nd BUSY cycle -> the next cycle mem_req=0, stall_mem=0, all counters 0. The following load completes normally.
